instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Downstream of the program counter: takes the current PC, fetches one instruction
//   from instruction memory over a req/gnt + rvalid handshake, and latches it into the
//   instruction register (IR). Also produces PC+4 for the next-PC mux.
//   Driven by the multicycle control FSM: a fetch_start pulse begins a fetch, and a
//   fetch_done pulse returns control to the FSM.
// PARAMETERS
//   WIDTH           32   PC / instruction-memory address width
//   INSTR_WIDTH     32   instruction width
//   TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before abort (>=2, fits in 8 bits)
// PORTS
//   clk             in   1            single clock, rising edge
//   rst             in   1            synchronous, active-high reset
//   fetch_start_in  in   1            1-cycle pulse: fetch at pc_in
//   pc_in           in   WIDTH        PC value, sampled only when fetch_start_in is accepted
//   imem_req_out    out  1            memory request valid
//   imem_addr_out   out  WIDTH        request address, stable while imem_req_out=1
//   imem_gnt_in     in   1            memory accepts request this cycle
//   imem_rvalid_in  in   1            read data valid
//   imem_rdata_in   in   INSTR_WIDTH  read data
//   ir_out          out  INSTR_WIDTH  instruction register
//   pc_plus4_out    out  WIDTH        captured PC + 4
//   fetch_done_out  out  1            1-cycle pulse: fetch finished (ok or error)
//   busy_out        out  1            high in REQ or WAIT
//   fetch_err_out   out  1            error flag for last fetch; held until next accepted start
// BEHAVIOUR
//   - Reset: state=IDLE; imem_req_out=0, imem_addr_out=0, ir_out=0, pc_plus4_out=0,
//     fetch_done_out=0, busy_out=0, fetch_err_out=0, timeout counter=0.
//   - Reset mid-fetch aborts on that edge: no done pulse, ir_out=0. A later rvalid is ignored.
//   - IDLE: fetch_start_in=1 -> capture addr=pc_in, pc_plus4_out=pc_in+4 (mod 2^WIDTH,
//     wraps, no carry out), clear fetch_err_out and counter, go REQ.
//   - REQ: imem_req_out=1 and address held until imem_gnt_in=1, then go WAIT.
//   - WAIT: on the first imem_rvalid_in=1, load ir_out<=imem_rdata_in, pulse
//     fetch_done_out on the next cycle, and go IDLE.
//   - rvalid is accepted no earlier than the cycle after gnt. rvalid in IDLE or REQ is ignored.
//   - Minimum latency: start@T0, req@T1, gnt@T1, rvalid@T2, then ir_out/done valid @T3.
//     ir_out changes only on a successful fetch.
//   - fetch_start_in while busy_out=1 or fetch_done_out=1 is ignored (no queueing).
//   - Timeout: the counter increments each cycle in REQ or WAIT. When it reaches
//     TIMEOUT_CYCLES:
//       - drop the request and go IDLE;
//       - pulse fetch_done_out and set fetch_err_out=1;
//       - leave ir_out unchanged.
//     rvalid in the same cycle as timeout wins: normal completion, no error.
//   - Timeout is measured from entry to REQ.
//   - imem_req_out is registered, with no combinational path from any input.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined: at an accepted start with pc_in[1:0]!=0:
//     - no memory request is issued and the unit stays IDLE;
//     - fetch_done_out pulses the next cycle with fetch_err_out=1;
//     - ir_out is unchanged; pc_plus4_out is still updated.
//   FETCH_ALIGN_CHECK_EN undefined: imem_addr_out[1:0] is forced to 2'b00, so a
//   misaligned PC fetches the word-aligned address and never raises an error.
// TESTING
//   1 pc_in=0x100, gnt same cycle as req, rvalid next, rdata=0x8B020020 -> ir_out=0x8B020020,
//     pc_plus4_out=0x104, done 1 pulse at T3, err=0.
//   2 gnt delayed 3 cycles and rvalid 2 more -> addr stable throughout, exactly one done,
//     busy_out high from T1 until the done cycle.
//   3 TIMEOUT_CYCLES=8, no gnt -> req drops after 8 cycles, done+err=1, ir_out keeps its
//     old value; the next good fetch clears err.
//   4 pc_in=0xFFFFFFFC -> pc_plus4_out=0x00000000.
//     fetch_start_in pulsed while busy -> ignored, one fetch only.
//   5 rst asserted in WAIT, then a stray rvalid -> all outputs at reset values, no done, IDLE.
//   6 with FETCH_ALIGN_CHECK_EN, pc_in=0x102 -> no req, done+err next cycle.
//     Without it -> imem_addr_out=0x100, err=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : instr_fetch_unit
// Description : Fetches one instruction at the given PC over a req/gnt + rvalid
//               handshake, latches it into the IR and produces PC+4.
//               Optional macro: FETCH_ALIGN_CHECK_EN (misaligned PC -> error).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
    parameter int WIDTH          = 32,
    parameter int INSTR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_start_in,
    input  logic [WIDTH-1:0]       pc_in,
    output logic                   imem_req_out,
    output logic [WIDTH-1:0]       imem_addr_out,
    input  logic                   imem_gnt_in,
    input  logic                   imem_rvalid_in,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
    output logic [INSTR_WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0]       pc_plus4_out,
    output logic                   fetch_done_out,
    output logic                   busy_out,
    output logic                   fetch_err_out
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_req;
    logic                   r_done;
    logic                   r_err;
    logic [WIDTH-1:0]       r_addr;
    logic [WIDTH-1:0]       r_pc4;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [7:0]             r_cnt;

    logic                   w_accept;
    logic                   w_misalign;
    logic                   w_busy;
    logic [7:0]             w_cnt_next;
    logic                   w_cnt_hit;
    logic                   w_load_ir;
    logic                   w_timeout;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign = |pc_in[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // A start coinciding with the done pulse is dropped, not queued.
    assign w_accept   = fetch_start_in && (r_state == S_IDLE) && !r_done;
    assign w_busy     = (r_state != S_IDLE);
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_cnt_hit  = (w_cnt_next == c_TIMEOUT);
    assign w_load_ir  = (r_state == S_WAIT) && imem_rvalid_in;
    // Data arriving on the final cycle completes the fetch instead of timing out.
    assign w_timeout  = w_busy && w_cnt_hit && !w_load_ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == S_REQ);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misalign) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (imem_gnt_in) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_load_ir || w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_pc4  <= '0;
            r_ir   <= '0;
            r_cnt  <= '0;
        end else begin
            r_done <= w_load_ir || w_timeout || (w_accept && w_misalign);
            if (w_accept) begin
                r_addr <= {pc_in[WIDTH-1:2], 2'b00};
                r_pc4  <= pc_in + WIDTH'(4);
                r_err  <= w_misalign;
                r_cnt  <= '0;
            end else if (w_busy) begin
                r_cnt <= w_cnt_next;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_load_ir) begin
                r_ir <= imem_rdata_in;
            end
        end
    end

    assign imem_req_out   = r_req;
    assign imem_addr_out  = r_addr;
    assign ir_out         = r_ir;
    assign pc_plus4_out   = r_pc4;
    assign fetch_done_out = r_done;
    assign busy_out       = w_busy;
    assign fetch_err_out  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit with an expected-result
//               queue popped on every fetch_done_out pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

    localparam int c_TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start_in;
    logic [31:0] pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] ir_out;
    logic [31:0] pc_plus4_out;
    logic        fetch_done_out;
    logic        busy_out;
    logic        fetch_err_out;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_ir;
    int          n_cmp = 0;
    int          n_err = 0;

    instr_fetch_unit #(
        .WIDTH          (32),
        .INSTR_WIDTH    (32),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_start_in (fetch_start_in),
        .pc_in          (pc_in),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_gnt_in    (imem_gnt_in),
        .imem_rvalid_in (imem_rvalid_in),
        .imem_rdata_in  (imem_rdata_in),
        .ir_out         (ir_out),
        .pc_plus4_out   (pc_plus4_out),
        .fetch_done_out (fetch_done_out),
        .busy_out       (busy_out),
        .fetch_err_out  (fetch_err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && fetch_done_out) begin
            exp_t e;
            check("busy_in_done", 64'(busy_out), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ir", 64'(ir_out), 64'(e.ir));
                check("pc4", 64'(pc_plus4_out), 64'(e.pc4));
                check("err", 64'(fetch_err_out), 64'(e.err));
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input int gdly, input int rdly,
                         input logic [31:0] data, input bit tmo, input bit poke);
        exp_t        e;
        int          n;
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        @(negedge clk);
        fetch_start_in = 1'b1;
        pc_in          = pc;
        if (!tmo) exp_ir = data;
        e.ir  = exp_ir;
        e.pc4 = pc + 32'd4;
        e.err = tmo;
        sb.push_back(e);
        @(negedge clk);
        fetch_start_in = 1'b0;
        pc_in          = 32'hA5A5_A5A5;
        check("req_T1", 64'(imem_req_out), 64'd1);
        check("busy_T1", 64'(busy_out), 64'd1);
        check("addr_T1", 64'(imem_addr_out), 64'(a));
        if (tmo) begin
            n = 0;
            while (imem_req_out && n < 300) begin
                check("addr_hold_tmo", 64'(imem_addr_out), 64'(a));
                n++;
                @(negedge clk);
            end
            check("tmo_cycles", 64'(n), 64'(c_TMO));
            check("tmo_done", 64'(fetch_done_out), 64'd1);
            @(negedge clk);
        end else begin
            for (int i = 0; i < gdly; i++) begin
                check("addr_hold", 64'(imem_addr_out), 64'(a));
                check("req_hold", 64'(imem_req_out), 64'd1);
                // rvalid while still requesting must not be taken as data
                imem_rvalid_in = (i == 1);
                imem_rdata_in  = 32'hDEAD_DEAD;
                fetch_start_in = poke && (i == 0);
                pc_in          = 32'h0000_0200;
                @(negedge clk);
            end
            imem_rvalid_in = 1'b0;
            fetch_start_in = 1'b0;
            check("addr_gnt", 64'(imem_addr_out), 64'(a));
            check("req_gnt", 64'(imem_req_out), 64'd1);
            imem_gnt_in = 1'b1;
            @(negedge clk);
            imem_gnt_in = 1'b0;
            for (int i = 1; i < rdly; i++) begin
                check("busy_wait", 64'(busy_out), 64'd1);
                check("done_early", 64'(fetch_done_out), 64'd0);
                @(negedge clk);
            end
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = data;
            @(negedge clk);
            imem_rvalid_in = 1'b0;
            imem_rdata_in  = $urandom;
            check("done_lat", 64'(fetch_done_out), 64'd1);
            check("req_low", 64'(imem_req_out), 64'd0);
            if (poke) begin
                fetch_start_in = 1'b1;
                pc_in          = 32'h0000_0300;
            end
            @(negedge clk);
            fetch_start_in = 1'b0;
            if (poke) begin
                check("ignored_start", 64'(imem_req_out), 64'd0);
                check("done_once", 64'(fetch_done_out), 64'd0);
                @(negedge clk);
                check("ignored_start2", 64'(imem_req_out), 64'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst            = 1'b1;
        fetch_start_in = 1'b0;
        pc_in          = '0;
        imem_gnt_in    = 1'b0;
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = '0;
        exp_ir         = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 64'(imem_req_out), 64'd0);
        check("rst_addr", 64'(imem_addr_out), 64'd0);
        check("rst_ir", 64'(ir_out), 64'd0);
        check("rst_pc4", 64'(pc_plus4_out), 64'd0);
        check("rst_done", 64'(fetch_done_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_err", 64'(fetch_err_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h0000_0100, 0, 1, 32'h8B02_0020, 1'b0, 1'b0);
        fetch(32'h0000_2000, 3, 2, 32'h1234_5678, 1'b0, 1'b0);
        fetch(32'h0000_3000, 0, 0, 32'h0,         1'b1, 1'b0);
        check("err_held", 64'(fetch_err_out), 64'd1);
        fetch(32'h0000_3004, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("err_cleared", 64'(fetch_err_out), 64'd0);
        fetch(32'hFFFF_FFFC, 2, 1, 32'h0BAD_BEEF, 1'b0, 1'b1);

        // reset while waiting for data, then stray rvalid
        @(negedge clk);
        fetch_start_in = 1'b1;
        pc_in          = 32'h0000_0400;
        @(negedge clk);
        fetch_start_in = 1'b0;
        imem_gnt_in    = 1'b1;
        @(negedge clk);
        imem_gnt_in = 1'b0;
        check("wait_busy", 64'(busy_out), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = 32'h7777_7777;
        exp_ir         = '0;
        @(negedge clk);
        imem_rvalid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("mrst_req", 64'(imem_req_out), 64'd0);
            check("mrst_addr", 64'(imem_addr_out), 64'd0);
            check("mrst_ir", 64'(ir_out), 64'd0);
            check("mrst_pc4", 64'(pc_plus4_out), 64'd0);
            check("mrst_done", 64'(fetch_done_out), 64'd0);
            check("mrst_busy", 64'(busy_out), 64'd0);
            check("mrst_err", 64'(fetch_err_out), 64'd0);
            @(negedge clk);
        end

`ifdef FETCH_ALIGN_CHECK_EN
        fetch_start_in = 1'b1;
        pc_in          = 32'h0000_0102;
        e.ir  = exp_ir;
        e.pc4 = 32'h0000_0106;
        e.err = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        fetch_start_in = 1'b0;
        check("mis_req", 64'(imem_req_out), 64'd0);
        check("mis_busy", 64'(busy_out), 64'd0);
        check("mis_done", 64'(fetch_done_out), 64'd1);
        @(negedge clk);
        check("mis_req2", 64'(imem_req_out), 64'd0);
        check("mis_done2", 64'(fetch_done_out), 64'd0);
`else
        e.err = 1'b0;
        fetch(32'h0000_0102, 0, 1, 32'h55AA_55AA, 1'b0, 1'b0);
        check("mis_noerr", 64'(fetch_err_out), 64'(e.err));
`endif
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
